serial_cfg_sequencer: RTL and testbench
=======================================

SERIAL_CFG_SEQUENCER -- requirements
Module: serial_cfg_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 32: shift-register length in bits.
REQ-002 SHALL have parameter DIV_W, default 8: width of clk_div.
REQ-003 SHALL have parameter LEN_W, default 16: width of load_len.
REQ-004 SHALL have one clock and an asynchronous, active-high reset: port clk, input, 1 bit, system clock (50 MHz).
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port req, input, 2 bits: level request per serial interface (bit0 = interface 1, bit1 = interface 2).
REQ-007 SHALL have port data0, input, WIDTH bits: word for interface 1.
REQ-008 SHALL have port data1, input, WIDTH bits: word for interface 2.
REQ-009 SHALL have port clk_div, input, DIV_W bits: serial half-period is clk_div+1 clk cycles.
REQ-010 SHALL have port load_len, input, LEN_W bits: loadData pulse length is load_len+1 clk cycles.
REQ-011 SHALL have port sclk, output, 2 bits: gated serial clock per interface (CLKin).
REQ-012 SHALL have port sdata, output, 2 bits: serial data per interface, MSB first.
REQ-013 SHALL have port load_data, output, 2 bits: loadData pulse per interface.
REQ-014 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-015 SHALL have port ack, output, 2 bits: one-cycle completion pulse per interface.

Function
REQ-016 SHALL implement FSM states IDLE, LOAD, SHIFT_LO, SHIFT_HI, GAP, PULSE, DONE.
REQ-017 IDLE: SHALL sample req on each edge; any bit set -> grant one interface, go to LOAD next cycle.
REQ-018 Arbitration: single request -> grant it; both -> grant the interface not granted last (round-robin); pointer after reset favours interface 1.
REQ-019 LOAD (1 cycle): SHALL capture granted dataN into shift register; latch clk_div and load_len; bit counter = WIDTH.
REQ-020 SHIFT_LO: sclk[g]=0, sdata[g]=shift MSB, hold clk_div+1 cycles -> SHIFT_HI.
REQ-021 SHIFT_HI: sclk[g]=1, sdata unchanged, hold clk_div+1 cycles; at exit shift left 1, decrement counter; counter reaches 0 -> GAP, else -> SHIFT_LO.
REQ-022 GAP: sclk and sdata low for 2*(clk_div+1) cycles -> PULSE.
REQ-023 PULSE: load_data[g]=1 for load_len+1 cycles -> DONE.
REQ-024 DONE (1 cycle): ack[g]=1 -> IDLE; round-robin pointer updated to g.
REQ-025 Total busy cycles per transfer SHALL be 1 + 2*WIDTH*(D+1) + 2*(D+1) + (L+1) + 1, with D=clk_div and L=load_len as latched.
REQ-026 Non-granted interface outputs (sclk, sdata, load_data, ack) SHALL stay 0 throughout a transfer.
REQ-027 req deassertion, or changes to data/clk_div/load_len after LOAD, SHALL NOT affect an ongoing transfer.
REQ-028 req still high in IDLE after ack SHALL start a new transfer; with both requests held, grants SHALL alternate 1,2,1,2.
REQ-029 All outputs SHALL be registered (no combinational path from req to sclk/sdata).

Reset
REQ-030 rst high, at any time including mid-shift, SHALL immediately force sclk=0, sdata=0, load_data=0, ack=0, busy=0, state IDLE, pointer to interface 1, and counters cleared.
REQ-031 After rst deasserts, the first req SHALL be honoured normally; no partial transfer SHALL resume.

Structure
REQ-032 Shared package qpix_ser_pkg SHALL hold the FSM state encoding and the default WIDTH/DIV_W/LEN_W constants.
REQ-033 A sub-module half_period_timer (loadable down-counter with terminal-count flag) SHALL be used for the SHIFT, GAP and PULSE durations.

Verification
REQ-034 req=01, data0=32'h12345678, clk_div=0, load_len=3 -> 32 sclk[0] pulses, sdata[0] reproduces 12345678 MSB-first on rising sclk, load_data[0] high 4 cycles, ack[0] after 72 busy cycles; all interface-2 outputs 0.
REQ-035 req=10, data1=32'hA0A0A0AF, clk_div=4 -> sclk[1] high/low phases of 5 cycles each; sdata[1] = A0A0A0AF; ack[1] once.
REQ-036 req=11 held for three transfers -> grant order 1,2,1; no cycle of overlap; ack bits alternate.
REQ-037 rst pulse during bit 10 of a transfer -> all outputs 0 in the same cycle, no ack; a later req=01 completes cleanly.
REQ-038 Change data0 and clk_div during SHIFT, and drop req after LOAD -> transmitted word and timing match the values latched at LOAD; ack still issued.
REQ-039 clk_div=255, load_len=65535 -> busy length equals the formula in REQ-025 exactly; no counter wrap.

Source files
------------

// File: rtl/qpix_ser_pkg.sv
// Shared definitions for the serial configuration sequencer: FSM encoding,
// default geometry constants and a small elaboration-time helper.
package qpix_ser_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_DIV_W = 8;
    localparam int DEF_LEN_W = 16;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        SHIFT_LO = 3'd2,
        SHIFT_HI = 3'd3,
        GAP      = 3'd4,
        PULSE    = 3'd5,
        DONE     = 3'd6
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/half_period_timer.sv
// Loadable down-counter; tc is high while the count sits at zero, so loading
// N-1 on entry to a state keeps that state active for exactly N cycles.
module half_period_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tc
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        // NOTE: default first so every path assigns count_d; no latch is inferred.
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q != '0) begin
            count_d = count_q - W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc = (count_q == '0);

endmodule

// File: rtl/serial_cfg_sequencer.sv
// Round-robin serialiser for two configuration interfaces: shifts a word out
// MSB first on a divided clock, then issues a loadData pulse and an ack.
module serial_cfg_sequencer
    import qpix_ser_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DIV_W = DEF_DIV_W,
    parameter int LEN_W = DEF_LEN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req,
    input  logic [WIDTH-1:0] data0,
    input  logic [WIDTH-1:0] data1,
    input  logic [DIV_W-1:0] clk_div,
    input  logic [LEN_W-1:0] load_len,
    output logic [1:0]       sclk,
    output logic [1:0]       sdata,
    output logic [1:0]       load_data,
    output logic             busy,
    output logic [1:0]       ack
);

    // GAP needs 2*(D+1)-1 = {D,1}, one bit wider than clk_div.
    localparam int TMR_W  = max_int(LEN_W, DIV_W + 1);
    localparam int BITS_W = $clog2(WIDTH + 1);

    state_t             state_q, state_d;
    logic               grant_q, grant_d;
    logic               last_q, last_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic [BITS_W-1:0]  bits_q, bits_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [1:0]         sclk_q, sclk_d;
    logic [1:0]         sdata_q, sdata_d;
    logic [1:0]         load_q, load_d;
    logic [1:0]         ack_q, ack_d;
    logic               busy_q, busy_d;
    logic               tmr_load;
    logic [TMR_W-1:0]   tmr_val;
    logic               tmr_tc;

    half_period_timer #(.W(TMR_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .tc       (tmr_tc)
    );

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        last_d   = last_q;
        shift_d  = shift_q;
        bits_d   = bits_q;
        div_d    = div_q;
        len_d    = len_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = LOAD;
                    grant_d = (&req) ? ~last_q : req[1];
                end
            end
            LOAD: begin
                shift_d  = grant_q ? data1 : data0;
                div_d    = clk_div;
                len_d    = load_len;
                bits_d   = BITS_W'(WIDTH);
                tmr_load = 1'b1;
                tmr_val[DIV_W-1:0] = clk_div;
                state_d  = SHIFT_LO;
            end
            SHIFT_LO: begin
                if (tmr_tc) begin
                    tmr_load = 1'b1;
                    tmr_val[DIV_W-1:0] = div_q;
                    state_d  = SHIFT_HI;
                end
            end
            SHIFT_HI: begin
                if (tmr_tc) begin
                    shift_d  = shift_q << 1;
                    bits_d   = bits_q - BITS_W'(1);
                    tmr_load = 1'b1;
                    if (bits_q == BITS_W'(1)) begin
                        tmr_val[DIV_W:0] = {div_q, 1'b1};
                        state_d = GAP;
                    end else begin
                        tmr_val[DIV_W-1:0] = div_q;
                        state_d = SHIFT_LO;
                    end
                end
            end
            GAP: begin
                if (tmr_tc) begin
                    tmr_load = 1'b1;
                    tmr_val[LEN_W-1:0] = len_q;
                    state_d  = PULSE;
                end
            end
            PULSE: begin
                if (tmr_tc) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                last_d  = grant_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the registered copies line up
    // with the state register.
    always_comb begin
        sclk_d  = '0;
        sdata_d = '0;
        load_d  = '0;
        ack_d   = '0;
        busy_d  = (state_d != IDLE);
        if (state_d == SHIFT_HI) sclk_d[grant_d] = 1'b1;
        if (state_d == SHIFT_LO || state_d == SHIFT_HI) sdata_d[grant_d] = shift_d[WIDTH-1];
        if (state_d == PULSE) load_d[grant_d] = 1'b1;
        if (state_d == DONE) ack_d[grant_d] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
            // NOTE: datapath registers are reset too, so an aborted word never leaks out.
            shift_q <= '0;
            bits_q  <= '0;
            div_q   <= '0;
            len_q   <= '0;
            sclk_q  <= '0;
            sdata_q <= '0;
            load_q  <= '0;
            ack_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            shift_q <= shift_d;
            bits_q  <= bits_d;
            div_q   <= div_d;
            len_q   <= len_d;
            sclk_q  <= sclk_d;
            sdata_q <= sdata_d;
            load_q  <= load_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
        end
    end

    assign sclk      = sclk_q;
    assign sdata     = sdata_q;
    assign load_data = load_q;
    assign ack       = ack_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_serial_cfg_sequencer.sv
// Directed bench for serial_cfg_sequencer: observes whole transfers and
// compares bit stream, phase lengths, pulse widths and busy length.
module tb_serial_cfg_sequencer;

    logic        clk;
    logic        rst;
    logic [1:0]  req;
    logic [31:0] data0;
    logic [31:0] data1;
    logic [7:0]  clk_div;
    logic [15:0] load_len;
    logic [1:0]  sclk;
    logic [1:0]  sdata;
    logic [1:0]  load_data;
    logic        busy;
    logic [1:0]  ack;

    int n_asserts = 0;
    int n_fail    = 0;

    int          obs_busy, obs_pulses, obs_ld, obs_ack, obs_other;
    int          obs_hi_min, obs_hi_max, obs_lo_min, obs_lo_max;
    logic [31:0] obs_word;

    serial_cfg_sequencer #(.WIDTH(32), .DIV_W(8), .LEN_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .data0     (data0),
        .data1     (data1),
        .clk_div   (clk_div),
        .load_len  (load_len),
        .sclk      (sclk),
        .sdata     (sdata),
        .load_data (load_data),
        .busy      (busy),
        .ack       (ack)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_asserts++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Waits for a transfer on interface g and records everything seen until busy drops.
    // At busy cycle pert_cycle, req is dropped and optionally data0/clk_div are scrambled.
    task automatic observe(input int g, input int pert_cycle, input bit pert_cfg);
        int  cyc, run;
        bit  prev, s, seen_rise;
        obs_busy = 0; obs_pulses = 0; obs_ld = 0; obs_ack = 0; obs_other = 0;
        obs_hi_min = 1 << 30; obs_hi_max = 0; obs_lo_min = 1 << 30; obs_lo_max = 0;
        obs_word = '0;
        for (int i = 0; i < 1000 && !busy; i++) @(negedge clk);
        check("xfer_start", busy, 1'b1);
        cyc = 0; run = 0; prev = 1'b0; seen_rise = 1'b0;
        while (busy && cyc < 100000) begin
            cyc++;
            s = sclk[g];
            if (s == prev) begin
                run++;
            end else begin
                if (prev) begin
                    if (run < obs_hi_min) obs_hi_min = run;
                    if (run > obs_hi_max) obs_hi_max = run;
                end else if (seen_rise) begin
                    if (run < obs_lo_min) obs_lo_min = run;
                    if (run > obs_lo_max) obs_lo_max = run;
                end
                if (s) begin
                    obs_pulses++;
                    obs_word  = {obs_word[30:0], sdata[g]};
                    seen_rise = 1'b1;
                end
                run = 1;
            end
            prev = s;
            if (load_data[g]) obs_ld++;
            if (ack[g]) obs_ack++;
            if (sclk[1-g] | sdata[1-g] | load_data[1-g] | ack[1-g]) obs_other++;
            if (cyc == pert_cycle) begin
                req = 2'b00;
                if (pert_cfg) begin
                    data0   = 32'hFFFF_FFFF;
                    clk_div = 8'd7;
                end
            end
            @(negedge clk);
        end
        obs_busy = cyc;
        check("xfer_end", busy, 1'b0);
    endtask

    task automatic expect_xfer(input string tag, input int busy_exp, input logic [31:0] word_exp,
                               input int half_exp, input int ld_exp);
        check({tag, ".busy"},   obs_busy,   busy_exp);
        check({tag, ".word"},   obs_word,   word_exp);
        check({tag, ".pulses"}, obs_pulses, 32);
        check({tag, ".hi_min"}, obs_hi_min, half_exp);
        check({tag, ".hi_max"}, obs_hi_max, half_exp);
        check({tag, ".lo_min"}, obs_lo_min, half_exp);
        check({tag, ".lo_max"}, obs_lo_max, half_exp);
        check({tag, ".ld"},     obs_ld,     ld_exp);
        check({tag, ".ack"},    obs_ack,    1);
        check({tag, ".other"},  obs_other,  0);
    endtask

    initial begin
        int acks_seen;
        rst = 1'b1; req = 2'b00; data0 = '0; data1 = '0; clk_div = '0; load_len = '0;
        repeat (2) @(negedge clk);
        check("reset.outputs", {sclk, sdata, load_data, ack, busy}, 9'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle.busy", busy, 1'b0);

        // Interface 1, fastest clock.
        data0 = 32'h1234_5678; clk_div = 8'd0; load_len = 16'd3; req = 2'b01;
        observe(0, -1, 1'b0);
        req = 2'b00;
        expect_xfer("if1_d0", 72, 32'h1234_5678, 1, 4);

        // Interface 2, divided clock.
        data1 = 32'hA0A0_A0AF; clk_div = 8'd4; load_len = 16'd3; req = 2'b10;
        observe(1, -1, 1'b0);
        req = 2'b00;
        expect_xfer("if2_d4", 336, 32'hA0A0_A0AF, 5, 4);
        repeat (3) @(negedge clk);

        // Both requests held: grants alternate 1,2,1.
        data0 = 32'h0F0F_1234; data1 = 32'hCAFE_BABE; clk_div = 8'd0; load_len = 16'd0;
        req = 2'b11;
        observe(0, -1, 1'b0);
        expect_xfer("rr1", 69, 32'h0F0F_1234, 1, 1);
        observe(1, -1, 1'b0);
        expect_xfer("rr2", 69, 32'hCAFE_BABE, 1, 1);
        observe(0, -1, 1'b0);
        req = 2'b00;
        expect_xfer("rr3", 69, 32'h0F0F_1234, 1, 1);
        repeat (3) @(negedge clk);
        check("rr.idle", busy, 1'b0);

        // Reset during bit 10, then pointer must favour interface 1 again.
        data0 = 32'h1234_5678; clk_div = 8'd0; load_len = 16'd3; req = 2'b01;
        for (int i = 0; i < 1000 && !busy; i++) @(negedge clk);
        check("abort.start", busy, 1'b1);
        repeat (21) @(negedge clk);
        check("abort.shifting", busy, 1'b1);
        rst = 1'b1; req = 2'b00;
        #1;
        check("abort.outputs", {sclk, sdata, load_data, ack, busy}, 9'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        acks_seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ack != 2'b00 || busy) acks_seen++;
        end
        check("abort.no_resume", acks_seen, 0);
        req = 2'b11;
        observe(0, 3, 1'b0);
        expect_xfer("post_rst", 72, 32'h1234_5678, 1, 4);
        repeat (2) @(negedge clk);

        // Inputs disturbed mid-transfer must not matter.
        data0 = 32'h5A5A_C3C3; clk_div = 8'd1; load_len = 16'd2; req = 2'b01;
        observe(0, 10, 1'b1);
        expect_xfer("latched", 137, 32'h5A5A_C3C3, 2, 3);
        repeat (2) @(negedge clk);
        check("latched.idle", busy, 1'b0);

        // Largest divider and pulse length.
        data0 = 32'h8000_0001; clk_div = 8'd255; load_len = 16'd65535; req = 2'b01;
        observe(0, 2, 1'b0);
        expect_xfer("max", 82434, 32'h8000_0001, 256, 65536);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
